// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bits.
// Imported by alu_core and alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_CF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_W  = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational single-edge ALU ops (logic, add/sub, slt) with zf/of/cf/sf.
// Ports: op, a, b in; res, flags out (bit order from alu_pkg).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  res,
  output logic [FLAG_W-1:0] flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic           ovf;
  logic           cry;

  assign sum = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the unsigned borrow.
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    cry = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        cry = sum[WIDTH];
        ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        cry = dif[WIDTH];
        ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
              (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}},
                     ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
  end

  always_comb begin
    flags          = '0;
    flags[FLAG_ZF] = (res == '0);
    flags[FLAG_SF] = res[WIDTH-1];
    flags[FLAG_OF] = ovf;
    flags[FLAG_CF] = cry;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: IDLE/BUSY/DONE FSM, iterative SLL (and MUL
// when ALU_MUL_EN is defined), registered f/flags and a byte-select LED view.
// Ports: clk, rst_n, in_valid/in_ready, alu_op, a, b, out_valid/out_ready,
//        f, zf, of, cf, sf, led_sel, led.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SELW  = $clog2(WIDTH/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             of,
  output logic             cf,
  output logic             sf,
  input  logic [SELW-1:0]  led_sel,
  output logic [7:0]       led
);

  localparam int SHW = SELW + 3;
  localparam int CW  = $clog2(WIDTH) + 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    f_q, f_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    core_res;
  logic [FLAG_W-1:0]   core_flags;
  logic [WIDTH-1:0]    iter_res;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    mplr_q, mplr_d;
  logic                mul_q, mul_d;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (alu_op),
    .a     (a),
    .b     (b),
    .res   (core_res),
    .flags (core_flags)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

`ifdef ALU_MUL_EN
  assign iter_res = mul_q ? acc_q : shreg_q;
`else
  assign iter_res = shreg_q;
`endif

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    flags_d = flags_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mul_d   = mul_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_op == OP_SLL) begin
            shreg_d = a;
            cnt_d   = {{(CW-SHW){1'b0}}, b[SHW-1:0]};
            state_d = S_BUSY;
`ifdef ALU_MUL_EN
            mul_d   = 1'b0;
          end else if (alu_op == OP_MUL) begin
            shreg_d = a;
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            mul_d   = 1'b1;
            state_d = S_BUSY;
`endif
          end else begin
            f_d     = core_res;
            flags_d = core_flags;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          f_d              = iter_res;
          flags_d          = '0;
          flags_d[FLAG_ZF] = (iter_res == '0);
          flags_d[FLAG_SF] = iter_res[WIDTH-1];
          state_d          = S_DONE;
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
`ifdef ALU_MUL_EN
          // Shift-add: multiplicand in shreg, multiplier consumed LSB first.
          if (mplr_q[0]) acc_d = acc_q + shreg_q;
          mplr_d = mplr_q >> 1;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      flags_q <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef ALU_MUL_EN
      acc_q   <= '0;
      mplr_q  <= '0;
      mul_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      flags_q <= flags_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef ALU_MUL_EN
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mul_q   <= mul_d;
`endif
    end
  end

  assign f  = f_q;
  assign zf = flags_q[FLAG_ZF];
  assign of = flags_q[FLAG_OF];
  assign cf = flags_q[FLAG_CF];
  assign sf = flags_q[FLAG_SF];

  assign led = f_q[{led_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded random + directed bench for alu_seq (WIDTH=32).
// Issue side pushes expected results; a negedge monitor pops and compares.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_op;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          zf, of, cf, sf;
  logic [1:0]    led_sel;
  logic [7:0]    led;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zf        (zf),
    .of        (of),
    .cf        (cf),
    .sf        (sf),
    .led_sel   (led_sel),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         zf, of, cf, sf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rmode = 2;
  bit   seen  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results from the opcode table using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    longint r;
    e.of = 0; e.cf = 0; e.due = 0;
    case (op)
      4'd0: e.f = x & y;
      4'd1: e.f = x | y;
      4'd2: e.f = x ^ y;
      4'd3: e.f = ~(x | y);
      4'd4: begin
        e.f = x + y;
        r = sx + sy;
        e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.cf = (ux + uy) > 64'sd4294967295;
      end
      4'd5: begin
        e.f = x - y;
        r = sx - sy;
        e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.cf = ux < uy;
      end
      4'd6: e.f = (sx < sy) ? 32'd1 : 32'd0;
      4'd7: begin
        e.f = x << y[4:0];
        e.due = int'(y[4:0]) + 1;
      end
`ifdef ALU_MUL_EN
      4'd8: begin
        e.f = x * y;
        e.due = W + 1;
      end
`endif
      default: e.f = '0;
    endcase
    e.zf = (e.f == 0);
    e.sf = e.f[W-1];
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    exp_t e;
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("issue_timeout", 32'd1, 32'd0);
    in_valid = 1'b1;
    alu_op   = op;
    a        = x;
    b        = y;
    e = model(op, x, y);
    e.due = cyc + 1 + e.due;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare head of scoreboard whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc), 32'(sb[0].due));
          seen = 1;
        end
        chk("result_f", f, sb[0].f);
        chk("result_flags", {28'd0, zf, of, cf, sf},
            {28'd0, sb[0].zf, sb[0].of, sb[0].cf, sb[0].sf});
      end
      out_ready = (rmode == 0) ? ($urandom_range(0, 2) == 0)
                               : (rmode == 2);
      if (out_ready && sb.size() != 0) begin
        void'(sb.pop_front());
        seen = 0;
      end
    end else begin
      out_ready = (rmode == 2);
    end
  end

  initial begin
    int bad;
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    alu_op = '0;
    a = '0;
    b = '0;
    led_sel = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_f", f, 32'd0);
    chk("rst_flags", {28'd0, zf, of, cf, sf}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    rmode = 1;
    issue(4'd4, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    chk("add_ovf_f", f, 32'h8000_0000);
    chk("add_ovf_flags", {28'd0, zf, of, cf, sf}, 32'b0101);
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 rmode = 2;
    drain(20);

    issue(4'd5, 32'd5, 32'd5);
    wait_valid(10);
    chk("sub_eq_f", f, 32'd0);
    chk("sub_eq_zf_cf", {30'd0, zf, cf}, 32'b10);
    drain(20);

    issue(4'd5, 32'd0, 32'd1);
    wait_valid(10);
    chk("sub_borrow_f", f, 32'hFFFF_FFFF);
    chk("sub_borrow_flags", {28'd0, zf, of, cf, sf}, 32'b0011);
    drain(20);

    issue(4'd7, 32'd1, 32'd31);
    bad = 0;
    for (int k = 0; k < 100 && !out_valid; k++) begin
      @(negedge clk);
      if (!out_valid && in_ready) bad++;
    end
    chk("sll_in_ready_low", 32'(bad), 32'd0);
    chk("sll_f", f, 32'h8000_0000);
    drain(20);

    rmode = 1;
    issue(4'd1, 32'h1234_5678, 32'd0);
    wait_valid(10);
    led_sel = 2'd2;
    #1 chk("led_sel2", {24'd0, led}, 32'h34);
    led_sel = 2'd0;
    #1 chk("led_sel0", {24'd0, led}, 32'h78);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_op = 4'd4;
      a = $urandom;
      b = $urandom;
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_f", f, 32'h1234_5678);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    rmode = 2;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    chk("release_f_kept", f, 32'h1234_5678);
    drain(5);

    issue(4'hF, $urandom, $urandom);
    wait_valid(10);
    chk("illegal_f", f, 32'd0);
    chk("illegal_zf", {31'd0, zf}, 32'd1);
    drain(20);

    issue(4'd7, 32'd1, 32'd20);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    seen = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_f", f, 32'd0);
    chk("midrst_io", {30'd0, out_valid, in_ready}, 32'b01);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("midrst_no_late", 32'(bad), 32'd0);

    rmode = 0;
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      if (n % 4 == 0) op = 4'd4;
      if (n % 4 == 1) op = 4'd5;
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 2) ra = 32'h8000_0000;
      if (n % 8 == 3) rb = ra;
      issue(op, ra, rb);
    end
    drain(3000);
    rmode = 2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
